// File: rtl/i_cache_refill_ctrl.sv
// I-cache line refill sequencer: stalls fetch, reads an aligned line word by word, writes the slice, reprograms its window.
// Optional macro REFILL_PERF_EN adds refill and stall-cycle performance counters.
module i_cache_refill_ctrl #(
    parameter int unsigned LINE_WORDS = 256,
    parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_address,
    input  logic        i_cache_miss,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        refill_enable,
    output logic [31:0] refill_address,
    output logic [31:0] refill_data,
    output logic [31:0] set_base_addr,
    output logic [31:0] set_bound_addr,
    output logic        base_addr_we,
    output logic        bound_addr_we,
    output logic [31:0] perf_miss_count,
    output logic [31:0] perf_stall_cycles
);

    localparam logic [31:0]      LINE_BYTES = 32'(4 * LINE_WORDS);
    localparam logic [31:0]      LINE_MASK  = ~(LINE_BYTES - 32'd1);
    localparam logic [IDX_W-1:0] K_LAST     = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_SET_BASE,
        S_SET_BOUND
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_k;
    logic [31:0]       r_line_base;
    logic              r_cpu_stall;
    logic              r_mem_req;
    logic [31:0]       r_mem_addr;
    logic              r_refill_enable;
    logic [IDX_W-1:0]  r_refill_address;
    logic [31:0]       r_refill_data;
    logic [31:0]       r_set_base;
    logic [31:0]       r_set_bound;
    logic              r_base_we;
    logic              r_bound_we;

    logic [IDX_W-1:0]  w_k_inc;
    logic [31:0]       w_next_addr;
    logic [31:0]       w_fetch_base;

    assign w_k_inc      = r_k + IDX_W'(1);
    assign w_next_addr  = r_line_base + (32'(w_k_inc) << 2);
    assign w_fetch_base = fetch_address & LINE_MASK;

    // Sequencer; every output register is loaded on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_k              <= '0;
            r_line_base      <= '0;
            r_cpu_stall      <= 1'b0;
            r_mem_req        <= 1'b0;
            r_mem_addr       <= '0;
            r_refill_enable  <= 1'b0;
            r_refill_address <= '0;
            r_refill_data    <= '0;
            r_set_base       <= '0;
            r_set_bound      <= '0;
            r_base_we        <= 1'b0;
            r_bound_we       <= 1'b0;
        end else begin
            r_refill_enable <= 1'b0;
            r_base_we       <= 1'b0;
            r_bound_we      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cache_miss) begin
                        r_line_base <= w_fetch_base;
                        r_k         <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_fetch_base;
                        r_cpu_stall <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_refill_data    <= mem_rdata;
                        r_refill_address <= r_k;
                        r_refill_enable  <= 1'b1;
                        r_state          <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_k == K_LAST) begin
                        r_set_base <= r_line_base;
                        r_base_we  <= 1'b1;
                        r_state    <= S_SET_BASE;
                    end else begin
                        r_k        <= w_k_inc;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_next_addr;
                        r_state    <= S_REQ;
                    end
                end
                S_SET_BASE: begin
                    // Bound cannot overflow: line_base is line-aligned.
                    r_set_bound <= r_line_base + LINE_BYTES - 32'd4;
                    r_bound_we  <= 1'b1;
                    r_state     <= S_SET_BOUND;
                end
                S_SET_BOUND: begin
                    r_cpu_stall <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_mem_req   <= 1'b0;
                    r_cpu_stall <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_stall      = r_cpu_stall;
    assign mem_req        = r_mem_req;
    assign mem_addr       = r_mem_addr;
    assign refill_enable  = r_refill_enable;
    assign refill_address = 32'(r_refill_address);
    assign refill_data    = r_refill_data;
    assign set_base_addr  = r_set_base;
    assign set_bound_addr = r_set_bound;
    assign base_addr_we   = r_base_we;
    assign bound_addr_we  = r_bound_we;

`ifdef REFILL_PERF_EN
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_stall;

    // Free-running wrap-around counters for refills started and stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_miss  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_state == S_IDLE && i_cache_miss) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
            if (r_cpu_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_miss_count   = r_perf_miss;
    assign perf_stall_cycles = r_perf_stall;
`else
    assign perf_miss_count   = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_i_cache_refill_ctrl.sv
// Bench for i_cache_refill_ctrl at LINE_WORDS=4: cycle table, randomized refills against a line-level model, reset corner.
module tb_i_cache_refill_ctrl;

    localparam int unsigned LW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_address = '0;
    logic        i_cache_miss = 1'b0;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        refill_enable;
    logic [31:0] refill_address;
    logic [31:0] refill_data;
    logic [31:0] set_base_addr;
    logic [31:0] set_bound_addr;
    logic        base_addr_we;
    logic        bound_addr_we;
    logic [31:0] perf_miss_count;
    logic [31:0] perf_stall_cycles;

    i_cache_refill_ctrl #(.LINE_WORDS(LW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_address    (fetch_address),
        .i_cache_miss     (i_cache_miss),
        .cpu_stall        (cpu_stall),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .refill_enable    (refill_enable),
        .refill_address   (refill_address),
        .refill_data      (refill_data),
        .set_base_addr    (set_base_addr),
        .set_bound_addr   (set_bound_addr),
        .base_addr_we     (base_addr_we),
        .bound_addr_we    (bound_addr_we),
        .perf_miss_count  (perf_miss_count),
        .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: grant after gnt_delay extra REQ cycles, data rv_delay extra cycles after grant.
    int          gnt_delay = 0;
    int          rv_delay = 0;
    logic [31:0] salt = '0;
    bit          stray_rv = 1'b0;
    int          g_cnt = 0;
    int          rv_cnt = 0;
    bit          rv_pend = 1'b0;
    logic [31:0] rv_addr = '0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (32'hA0 + ((a >> 2) & 32'(LW - 1))) ^ salt;
    endfunction

    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = stray_rv;
        if (!rst_n) begin
            rv_pend = 1'b0;
            g_cnt   = gnt_delay;
        end else if (rv_pend) begin
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data_of(rv_addr);
                rv_pend    = 1'b0;
            end else begin
                rv_cnt--;
            end
        end else if (mem_req) begin
            if (g_cnt == 0) begin
                mem_gnt = 1'b1;
                rv_pend = 1'b1;
                rv_cnt  = rv_delay;
                rv_addr = mem_addr;
                g_cnt   = gnt_delay;
            end else begin
                g_cnt--;
            end
        end else begin
            g_cnt = gnt_delay;
        end
    end

    // Transaction monitor: collects writes/window updates, checks every requested address.
    bit          mon_en = 1'b0;
    int          mon_stall = 0;
    int          mon_base_n = 0;
    int          mon_bound_n = 0;
    logic [31:0] mon_base = '0;
    logic [31:0] mon_bound = '0;
    logic [31:0] mon_idx[$];
    logic [31:0] mon_dat[$];
    logic [31:0] exp_base = '0;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (cpu_stall) mon_stall++;
            if (refill_enable) begin
                mon_idx.push_back(refill_address);
                mon_dat.push_back(refill_data);
            end
            if (base_addr_we) begin
                mon_base_n++;
                mon_base = set_base_addr;
            end
            if (bound_addr_we) begin
                mon_bound_n++;
                mon_bound = set_bound_addr;
            end
            if (mem_req) begin
                checks++;
                if (mem_addr !== exp_base + 32'(mon_idx.size()) * 32'd4) begin
                    errors++;
                    $display("FAIL mem_addr: got 0x%08h expected 0x%08h", mem_addr,
                             exp_base + 32'(mon_idx.size()) * 32'd4);
                end
            end
        end
    end

    // One refill compared against the line-level model; miss/fetch are scrambled early in the refill.
    task automatic do_refill(input logic [31:0] fa, input int gd, input int rd,
                             input logic [31:0] s, input string tag);
        logic [31:0] base;
        int          cyc;
        base      = fa & ~32'(4 * LW - 1);
        gnt_delay = gd;
        rv_delay  = rd;
        salt      = s;
        exp_base  = base;
        mon_idx.delete();
        mon_dat.delete();
        mon_stall   = 0;
        mon_base_n  = 0;
        mon_bound_n = 0;
        mon_en      = 1'b1;
        @(posedge clk); #1;
        i_cache_miss  = 1'b1;
        fetch_address = fa;
        @(posedge clk); #1;
        cyc = 0;
        while (cpu_stall && cyc < 2000) begin
            if (cyc < 8) begin
                i_cache_miss  = 1'($urandom_range(0, 1));
                fetch_address = (cyc % 2 == 1) ? 32'h0000_8000 : $urandom;
            end else begin
                i_cache_miss = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_cache_miss = 1'b0;
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: stall still high after %0d cycles", tag, cyc);
        end
        chk({tag, " stall_cycles"}, 32'(mon_stall), 32'(LW * (3 + gd + rd) + 2));
        chk({tag, " n_writes"}, 32'(mon_idx.size()), 32'(LW));
        for (int i = 0; i < mon_idx.size() && i < int'(LW); i++) begin
            chk({tag, " w_idx"}, mon_idx[i], 32'(i));
            chk({tag, " w_data"}, mon_dat[i], data_of(base + 32'(4 * i)));
        end
        chk({tag, " n_base"}, 32'(mon_base_n), 32'd1);
        chk({tag, " base"}, mon_base, base);
        chk({tag, " n_bound"}, 32'(mon_bound_n), 32'd1);
        chk({tag, " bound"}, mon_bound, base + 32'(4 * LW) - 32'd4);
        mon_en = 1'b0;
    endtask

    typedef struct {
        logic        miss;
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        ren;
        logic [31:0] ridx;
        logic [31:0] rdata;
        logic        bwe;
        logic        dwe;
        logic [31:0] setv;
    } vec_t;

    function automatic vec_t mk(input logic miss, input logic stall, input logic req,
                                input logic [31:0] addr, input logic ren, input logic [31:0] ridx,
                                input logic [31:0] rdata, input logic bwe, input logic dwe,
                                input logic [31:0] setv);
        vec_t v;
        v.miss = miss; v.stall = stall; v.req = req; v.addr = addr; v.ren = ren;
        v.ridx = ridx; v.rdata = rdata; v.bwe = bwe; v.dwe = dwe; v.setv = setv;
        return v;
    endfunction

    vec_t tv[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Cycle-accurate basic refill of fetch address 0x1234, zero-wait memory.
        tv[0]  = mk(1, 0, 0, 0,          0, 0, 0,     0, 0, 0);
        tv[1]  = mk(0, 1, 1, 32'h1230,   0, 0, 0,     0, 0, 0);
        tv[2]  = mk(0, 1, 0, 0,          0, 0, 0,     0, 0, 0);
        tv[3]  = mk(0, 1, 0, 0,          1, 0, 32'hA0, 0, 0, 0);
        tv[4]  = mk(0, 1, 1, 32'h1234,   0, 0, 0,     0, 0, 0);
        tv[5]  = mk(0, 1, 0, 0,          0, 0, 0,     0, 0, 0);
        tv[6]  = mk(0, 1, 0, 0,          1, 1, 32'hA1, 0, 0, 0);
        tv[7]  = mk(0, 1, 1, 32'h1238,   0, 0, 0,     0, 0, 0);
        tv[8]  = mk(0, 1, 0, 0,          0, 0, 0,     0, 0, 0);
        tv[9]  = mk(0, 1, 0, 0,          1, 2, 32'hA2, 0, 0, 0);
        tv[10] = mk(0, 1, 1, 32'h123C,   0, 0, 0,     0, 0, 0);
        tv[11] = mk(0, 1, 0, 0,          0, 0, 0,     0, 0, 0);
        tv[12] = mk(0, 1, 0, 0,          1, 3, 32'hA3, 0, 0, 0);
        tv[13] = mk(0, 1, 0, 0,          0, 0, 0,     1, 0, 32'h1230);
        tv[14] = mk(0, 1, 0, 0,          0, 0, 0,     0, 1, 32'h123C);
        tv[15] = mk(0, 0, 0, 0,          0, 0, 0,     0, 0, 0);

        gnt_delay = 0;
        rv_delay  = 0;
        salt      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset stall", 32'(cpu_stall), 32'd0);
        chk("reset req", 32'(mem_req), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fetch_address = 32'h0000_1234;
        for (int c = 0; c < 16; c++) begin
            i_cache_miss = tv[c].miss;
            chk($sformatf("c%0d stall", c), 32'(cpu_stall), 32'(tv[c].stall));
            chk($sformatf("c%0d req", c), 32'(mem_req), 32'(tv[c].req));
            chk($sformatf("c%0d ren", c), 32'(refill_enable), 32'(tv[c].ren));
            chk($sformatf("c%0d base_we", c), 32'(base_addr_we), 32'(tv[c].bwe));
            chk($sformatf("c%0d bound_we", c), 32'(bound_addr_we), 32'(tv[c].dwe));
            if (tv[c].req) chk($sformatf("c%0d mem_addr", c), mem_addr, tv[c].addr);
            if (tv[c].ren) begin
                chk($sformatf("c%0d ridx", c), refill_address, tv[c].ridx);
                chk($sformatf("c%0d rdata", c), refill_data, tv[c].rdata);
            end
            if (tv[c].bwe) chk($sformatf("c%0d set_base", c), set_base_addr, tv[c].setv);
            if (tv[c].dwe) chk($sformatf("c%0d set_bound", c), set_bound_addr, tv[c].setv);
            @(posedge clk); #1;
        end

        // Second zero-wait refill right behind the first, then the performance counters.
        do_refill(32'h0000_2008, 0, 0, $urandom, "b2b");
`ifdef REFILL_PERF_EN
        chk("perf_miss", perf_miss_count, 32'd2);
        chk("perf_stall", perf_stall_cycles, 32'd28);
`else
        chk("perf_miss", perf_miss_count, 32'd0);
        chk("perf_stall", perf_stall_cycles, 32'd0);
`endif

        do_refill(32'h0004_5670, 3, 5, $urandom, "backpressure");
        do_refill(32'h0000_0104, 1, 0, $urandom, "miss_ignored");
        do_refill(32'hFFFF_FFF8, 0, 1, $urandom, "top");
        chk("top base", mon_base, 32'hFFFF_FFF0);
        chk("top bound", mon_bound, 32'hFFFF_FFFC);
        for (int n = 0; n < 8; n++) begin
            do_refill($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      $urandom, $sformatf("rand%0d", n));
        end

        // Reset mid-refill, then a stray read response must be ignored.
        gnt_delay = 1;
        rv_delay  = 2;
        @(posedge clk); #1;
        i_cache_miss  = 1'b1;
        fetch_address = 32'h0000_3000;
        @(posedge clk); #1;
        i_cache_miss = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst stall", 32'(cpu_stall), 32'd0);
        chk("rst req", 32'(mem_req), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst ren", 32'(refill_enable), 32'd0);
        chk("rst ridx", refill_address, 32'd0);
        chk("rst rdata", refill_data, 32'd0);
        chk("rst set_base", set_base_addr, 32'd0);
        chk("rst set_bound", set_bound_addr, 32'd0);
        chk("rst we", 32'({base_addr_we, bound_addr_we}), 32'd0);
        chk("rst perf_miss", perf_miss_count, 32'd0);
        chk("rst perf_stall", perf_stall_cycles, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n    = 1'b1;
        stray_rv = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("stray ren", 32'(refill_enable), 32'd0);
            chk("stray stall", 32'(cpu_stall), 32'd0);
            chk("stray req", 32'(mem_req), 32'd0);
        end
        stray_rv = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i_cache_refill_ctrl.md
Name: i_cache_refill_ctrl

Overview:
Refill sequencer for the word-addressable I-cache slice. On an I-cache window miss it stalls the core and fetches an aligned line of LINE_WORDS words from backing memory over a req/gnt/rvalid read port. It writes each word into the slice through the refill port, then reprograms the slice's base/bound registers to cover the new line. It sits between the I-cache slice, the fetch stage (stall) and the memory/bus fabric.

Parameters:
LINE_WORDS, 256, words per refill line; power of two, at least 2; must equal the slice's cache_size.
IDX_W, $clog2(LINE_WORDS), width of the word counter and refill_address index.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_address  input  32  current fetch byte address from the core
i_cache_miss  input  1  window-miss flag from the slice
cpu_stall  output  1  high while a refill is in progress
mem_req  output  1  read request to backing memory
mem_addr  output  32  byte address of the requested word
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data
refill_enable  output  1  slice write strobe
refill_address  output  32  word index into the slice, zero-extended, 0..LINE_WORDS-1
refill_data  output  32  word to write
set_base_addr  output  32  new window base
set_bound_addr  output  32  new window bound
base_addr_we  output  1  base write strobe
bound_addr_we  output  1  bound write strobe
perf_miss_count  output  32  refills started (REFILL_PERF_EN)
perf_stall_cycles  output  32  cycles with cpu_stall high (REFILL_PERF_EN)

Behaviour:
- The block uses one clock (clk). Reset rst_n is asynchronous and active-low.
- On reset, all outputs go to 0, the FSM goes to IDLE, and the counter goes to 0. Reset mid-refill abandons the line immediately; any outstanding memory response is then ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, WRITE, SET_BASE, SET_BOUND. All outputs are Moore outputs decoded from registered state and registers.
- IDLE: if i_cache_miss=1, capture line_base = fetch_address & ~(4*LINE_WORDS-1), clear the counter k, and go to REQ. Otherwise stay in IDLE.
- REQ: mem_req=1 and mem_addr = line_base + 4*k, both held stable until mem_gnt=1. On mem_gnt go to WAIT.
- WAIT: wait for mem_rvalid=1, then latch mem_rdata into the data register and go to WRITE. mem_rvalid is ignored in every other state.
- WRITE: assert refill_enable=1 for exactly one cycle, with refill_address=k and refill_data set to the latched word. If k==LINE_WORDS-1 go to SET_BASE. Otherwise increment k and go to REQ.
- SET_BASE: base_addr_we=1 with set_base_addr=line_base, then go to SET_BOUND. SET_BASE and SET_BOUND are separate cycles because the slice gives base priority over bound.
- SET_BOUND: bound_addr_we=1 with set_bound_addr = line_base + 4*LINE_WORDS - 4, then go to IDLE. The bound never overflows because line_base is aligned.
- cpu_stall = (state != IDLE). It rises the cycle after the miss is sampled and falls the cycle after SET_BOUND.
- Minimum latency with zero-wait memory: 3*LINE_WORDS + 2 cycles from REQ entry to IDLE.
- i_cache_miss and fetch_address are ignored outside IDLE. A miss that is still present on return to IDLE starts a new refill; with a correct window this does not happen.
- refill_address and refill_data hold their last values when refill_enable=0. set_* hold their last values when the strobes are low.
- mem_req is never asserted outside REQ. At most one request is outstanding at any time.

Optional Feature:
REFILL_PERF_EN
- Defined: perf_miss_count increments on each IDLE->REQ transition. perf_stall_cycles increments every cycle cpu_stall=1. Both counters wrap at 2^32 and reset to 0.
- Not defined: both counters are absent from the logic and the ports are tied to 0.

Test Plan:
- Reset: rst_n=0 mid-run -> all outputs 0, FSM in IDLE; a stray mem_rvalid after release produces no refill_enable.
- Basic refill (LINE_WORDS=4), fetch_address=0x0000_1234, miss at cycle 0, mem_gnt=1 in REQ, mem_rvalid next cycle with data 0xA0..0xA3:
  - mem_addr is 0x1230, 0x1234, 0x1238, 0x123C at cycles 1, 4, 7, 10.
  - refill_enable at cycles 3, 6, 9, 12, with index 0..3 and data 0xA0..0xA3.
  - base_addr_we at cycle 13 with 0x1230; bound_addr_we at cycle 14 with 0x123C.
  - cpu_stall high for cycles 1-14.
- Backpressure: mem_gnt delayed 3 cycles and mem_rvalid delayed 5 -> mem_req and mem_addr held stable throughout; no early refill_enable; total latency grows by 8 cycles per word.
- Miss ignored during refill: toggle i_cache_miss and fetch_address=0x8000 mid-line -> line_base and addresses unchanged.
- Top-of-memory: fetch_address=0xFFFF_FFF8, LINE_WORDS=4 -> base 0xFFFF_FFF0, bound 0xFFFF_FFFC, no wrap.
- REFILL_PERF_EN: two back-to-back refills at LINE_WORDS=4 with zero wait states -> perf_miss_count=2, perf_stall_cycles=28. Without the macro, both counters read 0.
